flash_prog_ctrl: RTL and testbench



---
 rtl/flash_ctrl_top_specific_pkg.sv | 37 +++
 rtl/flash_prog_timeout_cnt.sv | 34 +++
 rtl/flash_prog_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_flash_prog_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_top_specific_pkg.sv
`default_nettype none
// ============================================================================
// Package    : flash_ctrl_top_specific_pkg
// Description: Program command, partition, error and sequencer state types.
// Revision   : 1.0 - initial release
// ============================================================================
package flash_ctrl_top_specific_pkg;

    typedef enum logic [1:0] {
        FlashProgNormal = 2'd0,
        FlashProgRepair = 2'd1
    } flash_prog_e;

    typedef enum logic [1:0] {
        FlashPartData = 2'd0,
        FlashPartInfo = 2'd1
    } flash_part_e;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrType    = 3'd1,
        ErrPart    = 3'd2,
        ErrRange   = 3'd3,
        ErrTimeout = 3'd4
    } flash_prog_err_e;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCheck    = 3'd1,
        StWaitData = 3'd2,
        StProg     = 3'd3,
        StDone     = 3'd4,
        StErr      = 3'd5
    } flash_prog_state_e;

endpackage
`default_nettype wire

// File: rtl/flash_prog_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module     : flash_prog_timeout_cnt
// Description: Per-word PHY acknowledge watchdog; expires on its last count.
// Revision   : 1.0 - initial release
// ============================================================================
module flash_prog_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Expiry is only meaningful while counting, so the owner sees a clean flag.
    assign o_expired = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/flash_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : flash_prog_ctrl
// Description: Program sequencer: checks a command, then one PHY write per word.
// Revision   : 1.0 - initial release
// ============================================================================
module flash_prog_ctrl
    import flash_ctrl_top_specific_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int CNT_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  op_req_i,
    output logic                  op_gnt_o,
    input  logic [ADDR_WIDTH-1:0] op_addr_i,
    input  logic [CNT_WIDTH-1:0]  op_num_words_i,
    input  logic [1:0]            op_type_i,
    input  logic [1:0]            op_part_i,
    input  logic                  repair_en_i,
    input  logic                  info_en_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  phy_req_o,
    output logic [ADDR_WIDTH-1:0] phy_addr_o,
    output logic [DATA_WIDTH-1:0] phy_wdata_o,
    output logic [1:0]            phy_type_o,
    output logic [1:0]            phy_part_o,
    input  logic                  phy_ack_i,
    output logic                  busy_o,
    output logic                  op_done_o,
    output logic                  op_err_o,
    output logic [2:0]            err_code_o
);

    flash_prog_state_e     r_state;
    flash_prog_state_e     w_nextState;
    flash_prog_err_e       w_errCode;
    flash_prog_err_e       r_errCode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_wordsLeft;
    logic [1:0]            r_type;
    logic [1:0]            r_part;
    logic                  r_repairEn;
    logic                  r_infoEn;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_phyReq;
    logic                  r_busy;
    logic                  r_opDone;
    logic                  r_opErr;
    logic                  w_opGnt;
    logic                  w_wdataReady;
    logic                  w_tmoClr;
    logic                  w_tmoEn;
    logic                  w_expired;
    logic                  w_typeOk;
    logic                  w_partOk;
    logic [ADDR_WIDTH:0]   w_endAddr;

    // Permissions come from the values latched at grant, not the live inputs.
    assign w_typeOk  = (r_type == FlashProgNormal) || ((r_type == FlashProgRepair) && r_repairEn);
    assign w_partOk  = (r_part == FlashPartData) || ((r_part == FlashPartInfo) && r_infoEn);
    assign w_endAddr = {1'b0, r_addr} + (ADDR_WIDTH+1)'(r_wordsLeft);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_errCode   = ErrNone;
        case (r_state)
            StIdle: begin
                if (op_req_i) w_nextState = StCheck;
            end
            StCheck: begin
                if (!w_typeOk) begin
                    w_nextState = StErr;
                    w_errCode   = ErrType;
                end else if (!w_partOk) begin
                    w_nextState = StErr;
                    w_errCode   = ErrPart;
                end else if (w_endAddr[ADDR_WIDTH]) begin
                    w_nextState = StErr;
                    w_errCode   = ErrRange;
                end else begin
                    w_nextState = StWaitData;
                end
            end
            StWaitData: begin
                if (wdata_valid_i) w_nextState = StProg;
            end
            StProg: begin
                // An acknowledge on the expiry cycle still completes the word.
                if (phy_ack_i) begin
                    w_nextState = (r_wordsLeft == '0) ? StDone : StWaitData;
                end else if (w_expired) begin
                    w_nextState = StErr;
                    w_errCode   = ErrTimeout;
                end
            end
            StDone:  w_nextState = StIdle;
            StErr:   w_nextState = StIdle;
            default: w_nextState = StIdle;
        endcase
    end

    always_comb begin
        w_opGnt      = (r_state == StIdle) && op_req_i;
        w_wdataReady = (r_state == StWaitData);
        w_tmoEn      = (r_state == StProg);
        w_tmoClr     = (r_state != StProg);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_wordsLeft <= '0;
            r_type      <= '0;
            r_part      <= '0;
            r_repairEn  <= 1'b0;
            r_infoEn    <= 1'b0;
            r_wdata     <= '0;
            r_errCode   <= ErrNone;
            r_phyReq    <= 1'b0;
            r_busy      <= 1'b0;
            r_opDone    <= 1'b0;
            r_opErr     <= 1'b0;
        end else begin
            r_phyReq <= (w_nextState == StProg);
            r_busy   <= (w_nextState != StIdle);
            r_opDone <= (w_nextState == StDone) || (w_nextState == StErr);
            r_opErr  <= (w_nextState == StErr);
            if (w_opGnt) begin
                r_addr      <= op_addr_i;
                r_wordsLeft <= op_num_words_i;
                r_type      <= op_type_i;
                r_part      <= op_part_i;
                r_repairEn  <= repair_en_i;
                r_infoEn    <= info_en_i;
                r_errCode   <= ErrNone;
            end
            if ((r_state == StWaitData) && wdata_valid_i) begin
                r_wdata <= wdata_i;
            end
            if ((r_state == StProg) && phy_ack_i && (r_wordsLeft != '0)) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_wordsLeft <= r_wordsLeft - CNT_WIDTH'(1);
            end
            if (w_nextState == StErr) begin
                r_errCode <= w_errCode;
            end
        end
    end

    flash_prog_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_clr     (w_tmoClr),
        .i_en      (w_tmoEn),
        .o_expired (w_expired)
    );

    assign op_gnt_o      = w_opGnt;
    assign wdata_ready_o = w_wdataReady;
    assign phy_req_o     = r_phyReq;
    assign phy_addr_o    = r_addr;
    assign phy_wdata_o   = r_wdata;
    assign phy_type_o    = r_type;
    assign phy_part_o    = r_part;
    assign busy_o        = r_busy;
    assign op_done_o     = r_opDone;
    assign op_err_o      = r_opErr;
    assign err_code_o    = r_errCode;

endmodule
`default_nettype wire

// File: tb/tb_flash_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_flash_prog_ctrl
// Description: Table-driven self-checking bench for flash_prog_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_flash_prog_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  cnt;
        logic [1:0]  ptype;
        logic [1:0]  part;
        logic        repEn;
        logic        infEn;
        int          ackAt;
        logic        expErr;
        logic [2:0]  expCode;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        op_req_i = 1'b0;
    logic        op_gnt_o;
    logic [15:0] op_addr_i = '0;
    logic [3:0]  op_num_words_i = '0;
    logic [1:0]  op_type_i = '0;
    logic [1:0]  op_part_i = '0;
    logic        repair_en_i = 1'b0;
    logic        info_en_i = 1'b0;
    logic        wdata_valid_i = 1'b0;
    logic        wdata_ready_o;
    logic [31:0] wdata_i = '0;
    logic        phy_req_o;
    logic [15:0] phy_addr_o;
    logic [31:0] phy_wdata_o;
    logic [1:0]  phy_type_o;
    logic [1:0]  phy_part_o;
    logic        phy_ack_i = 1'b0;
    logic        busy_o;
    logic        op_done_o;
    logic        op_err_o;
    logic [2:0]  err_code_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_prog_ctrl u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .op_req_i       (op_req_i),
        .op_gnt_o       (op_gnt_o),
        .op_addr_i      (op_addr_i),
        .op_num_words_i (op_num_words_i),
        .op_type_i      (op_type_i),
        .op_part_i      (op_part_i),
        .repair_en_i    (repair_en_i),
        .info_en_i      (info_en_i),
        .wdata_valid_i  (wdata_valid_i),
        .wdata_ready_o  (wdata_ready_o),
        .wdata_i        (wdata_i),
        .phy_req_o      (phy_req_o),
        .phy_addr_o     (phy_addr_o),
        .phy_wdata_o    (phy_wdata_o),
        .phy_type_o     (phy_type_o),
        .phy_part_o     (phy_part_o),
        .phy_ack_i      (phy_ack_i),
        .busy_o         (busy_o),
        .op_done_o      (op_done_o),
        .op_err_o       (op_err_o),
        .err_code_o     (err_code_o)
    );

    function automatic logic [31:0] dataOf(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name);
        check(name, {op_gnt_o, wdata_ready_o, phy_req_o, phy_addr_o, phy_wdata_o, phy_type_o,
                     phy_part_o, busy_o, op_done_o, op_err_o, err_code_o}, 64'd0);
    endtask

    // Runs one command cycle by cycle; acknowledges each word on its ackAt-th
    // request cycle (0 = never) and optionally resets on the first request of word rstWord.
    task automatic runOp(input vec_t v, input int rstWord, output int words, output logic gotDone,
                         output logic gotErr, output logic [2:0] gotCode, output int reqHigh,
                         output int latReq, output int latDone);
        int   reqCnt;
        int   gCyc;
        int   postRst;
        logic granted;
        logic [15:0] wAddr;
        words = 0; gotDone = 1'b0; gotErr = 1'b0; gotCode = '0; reqHigh = 0;
        latReq = -1; latDone = -1; reqCnt = 0; gCyc = 0; postRst = -1; granted = 1'b0;
        op_addr_i = v.addr; op_num_words_i = v.cnt; op_type_i = v.ptype; op_part_i = v.part;
        repair_en_i = v.repEn; info_en_i = v.infEn;
        wdata_valid_i = 1'b1; wdata_i = dataOf(v.addr); op_req_i = 1'b1;
        for (int cyc = 0; cyc < 3000 && !gotDone && postRst < 6; cyc++) begin
            #3;
            if (!granted && op_gnt_o) begin
                granted = 1'b1;
                gCyc = cyc;
            end
            if (granted && cyc == gCyc + 1) check("busy_in_check", busy_o, 1);
            if (phy_req_o) begin
                if (latReq < 0) latReq = cyc - gCyc;
                if (reqCnt == 0) begin
                    wAddr = v.addr + 16'(words);
                    check("phy_addr", phy_addr_o, wAddr);
                    check("phy_wdata", phy_wdata_o, dataOf(wAddr));
                    check("phy_type", phy_type_o, v.ptype);
                    check("phy_part", phy_part_o, v.part);
                end
                reqCnt++;
                reqHigh++;
                if (words == rstWord && reqCnt == 1) rst_i = 1'b1;
                phy_ack_i = (reqCnt == v.ackAt) && !rst_i;
            end
            if (postRst >= 0) begin
                check("rst_no_done", op_done_o, 0);
                postRst++;
            end
            if (op_done_o) begin
                gotDone = 1'b1;
                gotErr = op_err_o;
                gotCode = err_code_o;
                latDone = cyc - gCyc;
            end
            @(posedge clk);
            #1;
            if (granted) op_req_i = 1'b0;
            if (phy_ack_i) begin
                words++;
                reqCnt = 0;
                wdata_i = dataOf(v.addr + 16'(words));
            end
            phy_ack_i = 1'b0;
            if (rst_i) begin
                rst_i = 1'b0;
                checkAllZero("rst_mid_outputs");
                postRst = 0;
            end
        end
        check("granted", granted, 1);
        op_req_i = 1'b0;
    endtask

    vec_t vecs[13];
    vec_t hv;
    int   words, reqHigh, latReq, latDone, expWords;
    logic gotDone, gotErr;
    logic [2:0] gotCode;

    initial begin
        //          addr      cnt  type  part  rep   inf   ack err   code
        vecs[0]  = '{16'h0010, 4'd3, 2'd0, 2'd0, 1'b0, 1'b0, 2, 1'b0, 3'd0};
        vecs[1]  = '{16'h0010, 4'd3, 2'd1, 2'd0, 1'b0, 1'b0, 2, 1'b1, 3'd1};
        vecs[2]  = '{16'h0100, 4'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1, 1'b0, 3'd0};
        vecs[3]  = '{16'h0000, 4'd1, 2'd2, 2'd0, 1'b1, 1'b1, 1, 1'b1, 3'd1};
        vecs[4]  = '{16'h0020, 4'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1, 1'b1, 3'd2};
        vecs[5]  = '{16'h0020, 4'd1, 2'd0, 2'd1, 1'b0, 1'b1, 3, 1'b0, 3'd0};
        vecs[6]  = '{16'h0000, 4'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1, 1'b1, 3'd2};
        vecs[7]  = '{16'hFFFE, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 3'd3};
        vecs[8]  = '{16'hFFFD, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1, 1'b0, 3'd0};
        vecs[9]  = '{16'hFFF0, 4'd15, 2'd1, 2'd1, 1'b1, 1'b1, 1, 1'b0, 3'd0};
        vecs[10] = '{16'h0000, 4'd0, 2'd3, 2'd3, 1'b1, 1'b1, 1, 1'b1, 3'd1};
        vecs[11] = '{16'hFFFF, 4'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1, 1'b1, 3'd2};
        vecs[12] = '{16'hFFFF, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2, 1'b0, 3'd0};

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset_outputs");
        rst_i = 1'b0;
        #1;
        checkAllZero("idle_outputs");

        foreach (vecs[i]) begin
            runOp(vecs[i], -1, words, gotDone, gotErr, gotCode, reqHigh, latReq, latDone);
            expWords = vecs[i].expErr ? 0 : int'(vecs[i].cnt) + 1;
            check($sformatf("v%0d_done", i), gotDone, 1);
            check($sformatf("v%0d_err", i), gotErr, vecs[i].expErr);
            check($sformatf("v%0d_code", i), gotCode, vecs[i].expCode);
            check($sformatf("v%0d_words", i), words, expWords);
            if (vecs[i].expErr) check($sformatf("v%0d_err_latency", i), latDone, 2);
            else check($sformatf("v%0d_req_latency", i), latReq, 3);
            check($sformatf("v%0d_code_held", i), err_code_o, vecs[i].expCode);
        end

        // Never acknowledged: request held for the full window, then timeout.
        hv = '{16'h0040, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 1'b1, 3'd4};
        runOp(hv, -1, words, gotDone, gotErr, gotCode, reqHigh, latReq, latDone);
        check("tmo_done", gotDone, 1);
        check("tmo_err", gotErr, 1);
        check("tmo_code", gotCode, 3'd4);
        check("tmo_req_cycles", reqHigh, 1024);
        check("tmo_req_dropped", phy_req_o, 0);

        // Acknowledge on the final allowed cycle wins over the timeout.
        hv = '{16'h0041, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1024, 1'b0, 3'd0};
        runOp(hv, -1, words, gotDone, gotErr, gotCode, reqHigh, latReq, latDone);
        check("late_ack_done", gotDone, 1);
        check("late_ack_err", gotErr, 0);
        check("late_ack_code", gotCode, 3'd0);
        check("late_ack_words", words, 1);
        check("late_ack_req_cycles", reqHigh, 1024);

        // Reset while programming the second word: no completion pulse.
        hv = '{16'h0080, 4'd3, 2'd0, 2'd0, 1'b0, 1'b0, 2, 1'b0, 3'd0};
        runOp(hv, 1, words, gotDone, gotErr, gotCode, reqHigh, latReq, latDone);
        check("rst_no_done_seen", gotDone, 0);
        check("rst_words_before", words, 1);

        // A fresh command after the reset runs to completion.
        runOp(vecs[0], -1, words, gotDone, gotErr, gotCode, reqHigh, latReq, latDone);
        check("post_rst_done", gotDone, 1);
        check("post_rst_err", gotErr, 0);
        check("post_rst_words", words, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
